// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_pkg
//  Purpose  : Shared definitions for the FPU operation sequencer.
//             - FPU function-code constants (FUNC_ADD .. FUNC_MOV)
//             - Helpers that classify a function code
//             - Sequencer FSM state encoding
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package fpu_pkg;

  // FPU function codes as seen on req_func / fpu_func
  localparam logic [3:0] FUNC_ADD  = 4'b0000;
  localparam logic [3:0] FUNC_SUB  = 4'b0001;
  localparam logic [3:0] FUNC_CEQ  = 4'b0010;
  localparam logic [3:0] FUNC_CLT  = 4'b0011;
  localparam logic [3:0] FUNC_CLE  = 4'b0100;
  localparam logic [3:0] FUNC_CGT  = 4'b0101;
  localparam logic [3:0] FUNC_CGE  = 4'b0110;
  localparam logic [3:0] FUNC_MFC1 = 4'b0111;
  localparam logic [3:0] FUNC_MTC1 = 4'b1000;
  localparam logic [3:0] FUNC_MOV  = 4'b1001;

  // Sequencer state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } seq_state_e;

  // Compare family: the result goes to the condition flag, not a regfile
  function automatic logic is_compare(input logic [3:0] func);
    return (func >= FUNC_CEQ) && (func <= FUNC_CGE);
  endfunction

  // Codes above FUNC_MOV are reserved and raise illegal_op
  function automatic logic is_legal(input logic [3:0] func);
    return func <= FUNC_MOV;
  endfunction

  // Pure data moves: their result is one of the operands
  function automatic logic is_move(input logic [3:0] func);
    return (func == FUNC_MFC1) || (func == FUNC_MTC1) || (func == FUNC_MOV);
  endfunction

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/fpu_seq_wb_mux.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_seq_wb_mux
//  Purpose  : Combinational writeback selection for the FPU sequencer.
//             Decodes the latched function code during the WB state into
//             the regfile strobes, destination/data and flag update.
//  Ports    : wb_en_i         - sequencer is in the WB state
//             func_i          - latched function code
//             fd_i            - latched destination register
//             result_i        - captured result
//             cc_i            - current condition flag (gates mov.s)
//             wb_fp_valid_o   - FP regfile write strobe
//             wb_gpr_valid_o  - GPR write strobe
//             wb_addr_o       - destination, 0 when no strobe
//             wb_data_o       - write data, 0 when no strobe
//             illegal_o       - reserved function code reached WB
//             cc_update_o     - load the condition flag at end of WB
//  Revision : 1.0 - initial release
// ============================================================================
module fpu_seq_wb_mux
  import fpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              wb_en_i,
  input  logic [3:0]        func_i,
  input  logic [REG_AW-1:0] fd_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic              cc_i,
  output logic              wb_fp_valid_o,
  output logic              wb_gpr_valid_o,
  output logic [REG_AW-1:0] wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              illegal_o,
  output logic              cc_update_o
);

  always_comb begin
    wb_fp_valid_o  = 1'b0;
    wb_gpr_valid_o = 1'b0;
    wb_addr_o      = '0;
    wb_data_o      = '0;
    illegal_o      = 1'b0;
    cc_update_o    = 1'b0;

    if (wb_en_i) begin
      if (!is_legal(func_i)) begin
        illegal_o = 1'b1;
      end else if (is_compare(func_i)) begin
        cc_update_o = 1'b1;
      end else begin
        unique case (func_i)
          FUNC_ADD, FUNC_SUB, FUNC_MTC1: wb_fp_valid_o  = 1'b1;
          FUNC_MFC1:                     wb_gpr_valid_o = 1'b1;
          // Conditional move: writes only when the flag set by an earlier
          // compare is high
          FUNC_MOV:                      wb_fp_valid_o  = cc_i;
          default:                       wb_fp_valid_o  = 1'b0;
        endcase
      end

      // Address and data are only presented alongside a strobe
      if (wb_fp_valid_o || wb_gpr_valid_o) begin
        wb_addr_o = fd_i;
        wb_data_o = result_i;
      end
    end
  end

endmodule : fpu_seq_wb_mux
`default_nettype wire

// File: rtl/fpu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_op_sequencer
//  Purpose  : Multi-cycle issue controller between instruction decode and a
//             combinational FPU datapath. Accepts one op at a time, reads
//             the FP operands, holds them on the datapath for EXEC_CYCLES
//             cycles, captures the result and issues one writeback (FP RF,
//             GPR or condition flag). Owns the architectural FP cc flag.
//  Config   : `define FPU_SEQ_FAST_MOVE_EN - mfc1/mtc1/mov.s bypass EXEC and
//             write back straight from the operand read (READ -> WB).
//  Ports    : clk, rst (async, active-high)
//             req_*        - op request, valid/ready handshake
//             rf_r*_addr/rf_r*_data - FP regfile combinational read
//             fpu_*        - datapath operands / function / result / flag
//             wb_*         - writeback strobes, destination and data
//             cc_flag      - FP condition flag
//             busy         - sequencer not idle
//             illegal_op   - one-cycle pulse for reserved function codes
//  Revision : 1.0 - initial release
// ============================================================================
module fpu_op_sequencer
  import fpu_pkg::*;
#(
  parameter int EXEC_CYCLES = 2,
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_func,
  input  logic [REG_AW-1:0] req_fs,
  input  logic [REG_AW-1:0] req_ft,
  input  logic [REG_AW-1:0] req_fd,
  input  logic [DATA_W-1:0] req_gpr,
  output logic [REG_AW-1:0] rf_ra_addr,
  output logic [REG_AW-1:0] rf_rb_addr,
  input  logic [DATA_W-1:0] rf_ra_data,
  input  logic [DATA_W-1:0] rf_rb_data,
  output logic [DATA_W-1:0] fpu_a,
  output logic [DATA_W-1:0] fpu_b,
  output logic [DATA_W-1:0] fpu_gpr,
  output logic [3:0]        fpu_func,
  input  logic [DATA_W-1:0] fpu_result,
  input  logic              fpu_cmp_flag,
  output logic              wb_fp_valid,
  output logic              wb_gpr_valid,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              cc_flag,
  output logic              busy,
  output logic              illegal_op
);

  // Counter reload value: counts EXEC_CYCLES-1 down to 0
  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

  seq_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;

  // Request latches
  logic [3:0]        func_q;
  logic [REG_AW-1:0] fs_q, ft_q, fd_q;
  logic [DATA_W-1:0] gpr_q;

  // Datapath operand registers; they only load on READ -> EXEC so the
  // datapath inputs are frozen for the whole execute window and hold
  // their last value otherwise
  logic [DATA_W-1:0] fpu_a_q, fpu_b_q, fpu_gpr_q;
  logic [3:0]        fpu_func_q;

  logic [DATA_W-1:0] result_q;
  logic              cmp_q;     // compare outcome waiting for WB
  logic              cc_q;      // architectural condition flag

  logic              accept;
  logic              exec_done;
  logic              fast_move;
  logic              cc_update;

`ifdef FPU_SEQ_FAST_MOVE_EN
  assign fast_move = is_move(func_q);
`else
  assign fast_move = 1'b0;
`endif

  assign accept    = (state_q == ST_IDLE) && req_valid;
  assign exec_done = (state_q == ST_EXEC) && (cnt_q == 4'd0);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (fast_move) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_EXEC;
          cnt_d   = EXEC_LAST;
        end
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_WB;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      func_q     <= 4'd0;
      fs_q       <= '0;
      ft_q       <= '0;
      fd_q       <= '0;
      gpr_q      <= '0;
      fpu_a_q    <= '0;
      fpu_b_q    <= '0;
      fpu_gpr_q  <= '0;
      fpu_func_q <= 4'd0;
      result_q   <= '0;
      cmp_q      <= 1'b0;
      cc_q       <= 1'b0;
    end else begin
      if (accept) begin
        func_q <= req_func;
        fs_q   <= req_fs;
        ft_q   <= req_ft;
        fd_q   <= req_fd;
        gpr_q  <= req_gpr;
      end

      if (state_q == ST_READ) begin
        if (fast_move) begin
          // Moves need no arithmetic: take the operand directly
          result_q <= (func_q == FUNC_MTC1) ? gpr_q : rf_ra_data;
        end else begin
          fpu_a_q    <= rf_ra_data;
          fpu_b_q    <= rf_rb_data;
          fpu_gpr_q  <= gpr_q;
          fpu_func_q <= func_q;
        end
      end

      if (exec_done) begin
        result_q <= fpu_result;
        cmp_q    <= fpu_cmp_flag;
      end

      // Flag changes at the end of WB, so a following mov.s sees it
      if (cc_update) begin
        cc_q <= cmp_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Writeback selection
  // --------------------------------------------------------------------------
  fpu_seq_wb_mux #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_wb_mux (
    .wb_en_i        (state_q == ST_WB),
    .func_i         (func_q),
    .fd_i           (fd_q),
    .result_i       (result_q),
    .cc_i           (cc_q),
    .wb_fp_valid_o  (wb_fp_valid),
    .wb_gpr_valid_o (wb_gpr_valid),
    .wb_addr_o      (wb_addr),
    .wb_data_o      (wb_data),
    .illegal_o      (illegal_op),
    .cc_update_o    (cc_update)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Gated with rst so the request side reads as not-ready while held in reset
  assign req_ready  = (state_q == ST_IDLE) && !rst;
  assign busy       = (state_q != ST_IDLE);
  assign rf_ra_addr = (state_q == ST_READ) ? fs_q : '0;
  assign rf_rb_addr = (state_q == ST_READ) ? ft_q : '0;
  assign fpu_a      = fpu_a_q;
  assign fpu_b      = fpu_b_q;
  assign fpu_gpr    = fpu_gpr_q;
  assign fpu_func   = fpu_func_q;
  assign cc_flag    = cc_q;

endmodule : fpu_op_sequencer
`default_nettype wire

// File: tb/tb_fpu_op_sequencer.sv
`timescale 1ns/1ps
module tb_fpu_op_sequencer;

  localparam int EXEC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [3:0]  req_func;
  logic [4:0]  req_fs, req_ft, req_fd;
  logic [31:0] req_gpr;
  logic [4:0]  rf_ra_addr, rf_rb_addr;
  logic [31:0] rf_ra_data, rf_rb_data;
  logic [31:0] fpu_a, fpu_b, fpu_gpr, fpu_result;
  logic [3:0]  fpu_func;
  logic        fpu_cmp_flag;
  logic        wb_fp_valid, wb_gpr_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        cc_flag, busy, illegal_op;

  logic [31:0] rf_mem [32];
  int          tests  = 0;
  int          failed = 0;
  logic        model_cc;

  always #5 clk = ~clk;

  fpu_op_sequencer #(.EXEC_CYCLES(EXEC), .DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
    .req_fs(req_fs), .req_ft(req_ft), .req_fd(req_fd), .req_gpr(req_gpr),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_gpr(fpu_gpr), .fpu_func(fpu_func),
    .fpu_result(fpu_result), .fpu_cmp_flag(fpu_cmp_flag),
    .wb_fp_valid(wb_fp_valid), .wb_gpr_valid(wb_gpr_valid),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .cc_flag(cc_flag), .busy(busy), .illegal_op(illegal_op)
  );

  // ---------------- float32 <-> real (normal numbers and zero) -------------
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    d = {f[31], e, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // ---------------- combinational FPU datapath stand-in --------------------
  function automatic logic [31:0] dp_result(input logic [3:0] f,
                                            input logic [31:0] a, b, g);
    case (f)
      4'd0:    return r2f(f2r(a) + f2r(b));
      4'd1:    return r2f(f2r(a) - f2r(b));
      4'd8:    return g;
      default: return a;
    endcase
  endfunction

  function automatic logic dp_flag(input logic [3:0] f, input logic [31:0] a, b);
    case (f)
      4'd2:    return f2r(a) == f2r(b);
      4'd3:    return f2r(a) <  f2r(b);
      4'd4:    return f2r(a) <= f2r(b);
      4'd5:    return f2r(a) >  f2r(b);
      4'd6:    return f2r(a) >= f2r(b);
      default: return 1'b0;
    endcase
  endfunction

  assign rf_ra_data   = rf_mem[rf_ra_addr];
  assign rf_rb_data   = rf_mem[rf_rb_addr];
  assign fpu_result   = dp_result(fpu_func, fpu_a, fpu_b, fpu_gpr);
  assign fpu_cmp_flag = dp_flag(fpu_func, fpu_a, fpu_b);

  // ---------------- reference model ----------------------------------------
  // kind: 0 no writeback, 1 FP regfile, 2 GPR, 3 illegal
  function automatic int exp_lat(input logic [3:0] f);
`ifdef FPU_SEQ_FAST_MOVE_EN
    if (f == 4'd7 || f == 4'd8 || f == 4'd9) return 1;
`endif
    return EXEC + 1;
  endfunction

  task automatic model_op(input logic [3:0] f, input logic [4:0] fs, ft, fd,
                          input logic [31:0] g, output int kind,
                          output logic [4:0] addr, output logic [31:0] data);
    real a, b;
    a = f2r(rf_mem[fs]);
    b = f2r(rf_mem[ft]);
    kind = 0; addr = 5'd0; data = 32'h0;
    if (f == 4'd0)      begin kind = 1; addr = fd; data = r2f(a + b); end
    else if (f == 4'd1) begin kind = 1; addr = fd; data = r2f(a - b); end
    else if (f == 4'd2) model_cc = (a == b);
    else if (f == 4'd3) model_cc = (a <  b);
    else if (f == 4'd4) model_cc = (a <= b);
    else if (f == 4'd5) model_cc = (a >  b);
    else if (f == 4'd6) model_cc = (a >= b);
    else if (f == 4'd7) begin kind = 2; addr = fd; data = rf_mem[fs]; end
    else if (f == 4'd8) begin kind = 1; addr = fd; data = g; end
    else if (f == 4'd9) begin
      if (model_cc) begin kind = 1; addr = fd; data = rf_mem[fs]; end
    end
    else kind = 3;
  endtask

  // ---------------- observation of one operation ---------------------------
  typedef struct {
    int          wait_cyc;
    int          ev_cyc;
    int          n_ev;
    int          busy_cyc;
    logic        fp, gpr, ill;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        stray, unstable, addr_bad;
    logic [4:0]  ra, rb;
    logic [31:0] a_seen, b_seen;
    logic [3:0]  func_seen;
    logic        cc_end, ready_end, busy_end;
  } obs_t;

  // Caller is at a negedge. Drives one request, waits for acceptance and
  // records what the DUT does from the READ cycle through the IDLE cycle.
  task automatic do_op(input logic [3:0] f, input logic [4:0] fs, ft, fd,
                       input logic [31:0] g, input logic hold, output obs_t o);
    int lat, last;
    o = '{default: 0};
    o.ev_cyc = -1;
    req_valid = 1'b1; req_func = f; req_fs = fs; req_ft = ft; req_fd = fd;
    req_gpr = g;
    while (!req_ready && o.wait_cyc < 50) begin
      @(negedge clk);
      o.wait_cyc++;
    end
    if (o.wait_cyc >= 50) begin
      req_valid = 1'b0;
      return;
    end
    lat  = exp_lat(f);
    last = lat + 1;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      if (c == 0) begin
        if (!hold) req_valid = 1'b0;
        else begin
          // Garbage while busy; must not be latched
          req_func = 4'hC; req_fs = 5'd31; req_ft = 5'd30; req_fd = 5'd29;
          req_gpr = 32'hFFFF_FFFF;
        end
      end
      if (c == last) req_valid = 1'b0;
      if (busy) o.busy_cyc++;
      if (wb_fp_valid || wb_gpr_valid || illegal_op) begin
        o.n_ev++;
        if (o.ev_cyc < 0) begin
          o.ev_cyc = c; o.fp = wb_fp_valid; o.gpr = wb_gpr_valid;
          o.ill = illegal_op; o.addr = wb_addr; o.data = wb_data;
        end
      end else if (wb_addr != 5'd0 || wb_data != 32'd0) begin
        o.stray = 1'b1;
      end
      if (c == 0) begin
        o.ra = rf_ra_addr; o.rb = rf_rb_addr;
      end else if (rf_ra_addr != 5'd0 || rf_rb_addr != 5'd0) begin
        o.addr_bad = 1'b1;
      end
      if (c == 1) begin
        o.a_seen = fpu_a; o.b_seen = fpu_b; o.func_seen = fpu_func;
      end else if (c > 1 && c < lat) begin
        if (fpu_a != o.a_seen || fpu_b != o.b_seen || fpu_func != o.func_seen)
          o.unstable = 1'b1;
      end
      if (c == last) begin
        o.cc_end = cc_flag; o.ready_end = req_ready; o.busy_end = busy;
      end
    end
  endtask

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_func = 4'd0; req_fs = 5'd0;
    req_ft = 5'd0; req_fd = 5'd0; req_gpr = 32'd0;
    repeat (3) @(negedge clk);
    tests++;
    if ({req_ready, busy, cc_flag, wb_fp_valid, wb_gpr_valid, illegal_op} !== 6'b0) begin
      failed++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {req_ready, busy, cc_flag, wb_fp_valid, wb_gpr_valid, illegal_op});
    end
    tests++;
    if ({wb_addr, wb_data, rf_ra_addr, rf_rb_addr, fpu_a, fpu_b, fpu_gpr, fpu_func} !== '0) begin
      failed++;
      $display("FAIL reset_data: wb_addr=%h wb_data=%h ra=%h rb=%h a=%h b=%h g=%h f=%h required all 0",
               wb_addr, wb_data, rf_ra_addr, rf_rb_addr, fpu_a, fpu_b, fpu_gpr, fpu_func);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      failed++;
      $display("FAIL reset_release: req_ready=%b busy=%b required 1/0", req_ready, busy);
    end
    model_cc = 1'b0;
  endtask

  task automatic test_add();
    obs_t o;
    rf_mem[1] = 32'h3F80_0000;
    rf_mem[2] = 32'h4000_0000;
    do_op(4'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, o);
    tests++;
    if (o.wait_cyc != 0) begin
      failed++; $display("FAIL add_accept: waited %0d cycles required 0", o.wait_cyc);
    end
    tests++;
    if (o.ev_cyc != EXEC + 1 || o.n_ev != 1) begin
      failed++;
      $display("FAIL add_latency: strobe cycle %0d count %0d required %0d/1",
               o.ev_cyc, o.n_ev, EXEC + 1);
    end
    tests++;
    if ({o.fp, o.gpr, o.ill, o.addr, o.data} !== {3'b100, 5'd3, 32'h4040_0000}) begin
      failed++;
      $display("FAIL add_wb: fp=%b gpr=%b ill=%b addr=%0d data=%h required 1 0 0 3 40400000",
               o.fp, o.gpr, o.ill, o.addr, o.data);
    end
    tests++;
    if (o.busy_cyc != EXEC + 2 || o.busy_end !== 1'b0 || o.ready_end !== 1'b1) begin
      failed++;
      $display("FAIL add_busy: busy cycles %0d end busy=%b ready=%b required %0d/0/1",
               o.busy_cyc, o.busy_end, o.ready_end, EXEC + 2);
    end
    tests++;
    if (o.a_seen !== 32'h3F80_0000 || o.b_seen !== 32'h4000_0000 ||
        o.func_seen !== 4'd0 || o.unstable) begin
      failed++;
      $display("FAIL add_operands: a=%h b=%h f=%h unstable=%b required 3f800000 40000000 0 0",
               o.a_seen, o.b_seen, o.func_seen, o.unstable);
    end
    tests++;
    if (o.ra !== 5'd1 || o.rb !== 5'd2 || o.addr_bad || o.stray) begin
      failed++;
      $display("FAIL add_rfaddr: ra=%0d rb=%0d bad=%b stray=%b required 1 2 0 0",
               o.ra, o.rb, o.addr_bad, o.stray);
    end
  endtask

  task automatic test_cmp_mov();
    obs_t o;
    do_op(4'd3, 5'd1, 5'd2, 5'd0, 32'd0, 1'b0, o);   // 1.0 < 2.0
    tests++;
    if (o.n_ev != 0 || o.cc_end !== 1'b1) begin
      failed++;
      $display("FAIL cmp_lt: events %0d cc=%b required 0/1", o.n_ev, o.cc_end);
    end
    do_op(4'd9, 5'd1, 5'd0, 5'd4, 32'd0, 1'b0, o);
    tests++;
    if (o.ev_cyc != exp_lat(4'd9) || {o.fp, o.gpr, o.addr, o.data} !== {2'b10, 5'd4, 32'h3F80_0000}) begin
      failed++;
      $display("FAIL movs_taken: cycle %0d fp=%b gpr=%b addr=%0d data=%h required %0d 1 0 4 3f800000",
               o.ev_cyc, o.fp, o.gpr, o.addr, o.data, exp_lat(4'd9));
    end
    do_op(4'd5, 5'd1, 5'd2, 5'd0, 32'd0, 1'b0, o);   // 1.0 > 2.0 false
    tests++;
    if (o.cc_end !== 1'b0) begin
      failed++; $display("FAIL cmp_gt: cc=%b required 0", o.cc_end);
    end
    do_op(4'd9, 5'd1, 5'd0, 5'd4, 32'd0, 1'b0, o);
    tests++;
    if (o.n_ev != 0 || o.stray || o.busy_cyc != exp_lat(4'd9) + 1) begin
      failed++;
      $display("FAIL movs_skipped: events %0d stray=%b busy %0d required 0 0 %0d",
               o.n_ev, o.stray, o.busy_cyc, exp_lat(4'd9) + 1);
    end
    model_cc = 1'b0;
  endtask

  task automatic test_mfc1();
    obs_t o;
    rf_mem[5] = 32'hDEAD_BEEF;
    do_op(4'd7, 5'd5, 5'd0, 5'd9, 32'd0, 1'b0, o);
    tests++;
    if (o.ev_cyc != exp_lat(4'd7) || o.n_ev != 1 ||
        {o.fp, o.gpr, o.ill, o.addr, o.data} !== {3'b010, 5'd9, 32'hDEAD_BEEF}) begin
      failed++;
      $display("FAIL mfc1_wb: cycle %0d fp=%b gpr=%b ill=%b addr=%0d data=%h required %0d 0 1 0 9 deadbeef",
               o.ev_cyc, o.fp, o.gpr, o.ill, o.addr, o.data, exp_lat(4'd7));
    end
  endtask

  task automatic test_illegal();
    obs_t o;
    do_op(4'd3, 5'd1, 5'd2, 5'd0, 32'd0, 1'b0, o);   // sets flag to 1
    model_cc = 1'b1;
    do_op(4'hC, 5'd1, 5'd2, 5'd6, 32'd0, 1'b0, o);
    tests++;
    if (o.ev_cyc != EXEC + 1 || o.n_ev != 1 ||
        {o.fp, o.gpr, o.ill, o.addr, o.data} !== {3'b001, 5'd0, 32'd0}) begin
      failed++;
      $display("FAIL illegal_pulse: cycle %0d n=%0d fp=%b gpr=%b ill=%b addr=%0d data=%h required %0d 1 0 0 1 0 0",
               o.ev_cyc, o.n_ev, o.fp, o.gpr, o.ill, o.addr, o.data, EXEC + 1);
    end
    tests++;
    if (o.cc_end !== 1'b1 || o.ready_end !== 1'b1) begin
      failed++;
      $display("FAIL illegal_state: cc=%b ready=%b required 1/1", o.cc_end, o.ready_end);
    end
  endtask

  task automatic test_hold_valid();
    obs_t o;
    do_op(4'd1, 5'd2, 5'd1, 5'd7, 32'd0, 1'b1, o);   // 2.0 - 1.0
    tests++;
    if (o.n_ev != 1 || o.ev_cyc != EXEC + 1 ||
        {o.fp, o.ill, o.addr, o.data} !== {2'b10, 5'd7, 32'h3F80_0000}) begin
      failed++;
      $display("FAIL hold_valid: n=%0d cycle %0d fp=%b ill=%b addr=%0d data=%h required 1 %0d 1 0 7 3f800000",
               o.n_ev, o.ev_cyc, o.fp, o.ill, o.addr, o.data, EXEC + 1);
    end
  endtask

  task automatic test_fast_move();
    obs_t o;
    do_op(4'd8, 5'd0, 5'd0, 5'd2, 32'h1234_5678, 1'b0, o);
    tests++;
    if (o.ev_cyc != exp_lat(4'd8) || o.n_ev != 1 ||
        {o.fp, o.gpr, o.addr, o.data} !== {2'b10, 5'd2, 32'h1234_5678}) begin
      failed++;
      $display("FAIL mtc1_wb: cycle %0d fp=%b gpr=%b addr=%0d data=%h required %0d 1 0 2 12345678",
               o.ev_cyc, o.fp, o.gpr, o.addr, o.data, exp_lat(4'd8));
    end
  endtask

  task automatic test_random();
    obs_t        o;
    int          kind, got_kind;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [3:0]  f;
    logic [4:0]  fs, ft, fd;
    logic [31:0] g;
    int          n;
    for (int r = 0; r < 32; r++) begin
      n = $urandom_range(0, 400);
      rf_mem[r] = (n == 0) ? 32'h0 :
                  r2f(($urandom_range(0, 1) != 0) ? -real'(n) : real'(n));
    end
    rf_mem[11] = rf_mem[10];
    for (int i = 0; i < 40; i++) begin
      f  = 4'($urandom_range(0, 15));
      fs = 5'($urandom_range(8, 15));
      ft = 5'($urandom_range(8, 15));
      fd = 5'($urandom_range(0, 31));
      g  = $urandom;
      model_op(f, fs, ft, fd, g, kind, ea, ed);
      do_op(f, fs, ft, fd, g, 1'b0, o);
      got_kind = (o.n_ev == 0) ? 0 : (o.fp ? 1 : (o.gpr ? 2 : (o.ill ? 3 : 4)));
      tests++;
      if (got_kind != kind || o.n_ev > 1 || o.stray ||
          (kind != 0 && (o.ev_cyc != exp_lat(f) || o.addr !== ea || o.data !== ed))) begin
        failed++;
        $display("FAIL rand_wb[%0d] func=%h: kind %0d n=%0d cyc %0d addr %0d data %h required kind %0d cyc %0d addr %0d data %h",
                 i, f, got_kind, o.n_ev, o.ev_cyc, o.addr, o.data, kind, exp_lat(f), ea, ed);
      end
      tests++;
      if (o.cc_end !== model_cc || o.wait_cyc != 0) begin
        failed++;
        $display("FAIL rand_cc[%0d] func=%h: cc=%b wait=%0d required %b/0",
                 i, f, o.cc_end, o.wait_cyc, model_cc);
      end
    end
  endtask

  task automatic test_reset_exec();
    int strobes = 0;
    int bad_idle = 0;
    rf_mem[1] = 32'h3F80_0000;
    rf_mem[2] = 32'h4000_0000;
    req_valid = 1'b1; req_func = 4'd0; req_fs = 5'd1; req_ft = 5'd2;
    req_fd = 5'd6; req_gpr = 32'd0;
    @(negedge clk);                  // READ
    req_valid = 1'b0;
    @(negedge clk);                  // first EXEC cycle
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({busy, req_ready, cc_flag, wb_fp_valid, wb_gpr_valid, illegal_op} !== 6'b0 ||
        {wb_addr, wb_data, fpu_a, fpu_b, fpu_gpr, fpu_func} !== '0) begin
      failed++;
      $display("FAIL rst_exec_outputs: busy=%b ready=%b cc=%b fp=%b gpr=%b ill=%b a=%h b=%h required all 0",
               busy, req_ready, cc_flag, wb_fp_valid, wb_gpr_valid, illegal_op, fpu_a, fpu_b);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      failed++;
      $display("FAIL rst_exec_release: req_ready=%b busy=%b required 1/0", req_ready, busy);
    end
    for (int c = 0; c < EXEC + 4; c++) begin
      @(negedge clk);
      if (wb_fp_valid || wb_gpr_valid || illegal_op) strobes++;
      if (busy || !req_ready || cc_flag) bad_idle++;
    end
    tests++;
    if (strobes != 0 || bad_idle != 0) begin
      failed++;
      $display("FAIL rst_exec_abort: strobes %0d non-idle cycles %0d required 0/0",
               strobes, bad_idle);
    end
    model_cc = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf_mem[r] = 32'h0;
    model_cc = 1'b0;
    test_reset();
    test_add();
    test_cmp_mov();
    test_mfc1();
    test_illegal();
    test_hold_valid();
    test_fast_move();
    test_random();
    test_reset_exec();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
